archer_run_ctrl: RTL and testbench

- Synthesizable run-control and completion monitor for one or more archer_rv32if harts; replaces the fixed-delay reset/stop sequencing with a parametrised, cycle-exact controller.
- Drives each hart's active-low reset, counts run cycles, watches each hart's data-store port for writes to a "tohost" address, and reports pass, fail or timeout.
- Sits between the top-level clock/reset and the hart instances; usable in simulation benches and FPGA bring-up.

---
 rtl/archer_pkg.sv | 14 +
 rtl/archer_tohost_decode.sv | 20 ++
 rtl/archer_run_ctrl.sv | 149 ++++++++++++++
 tb/tb_archer_run_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/archer_pkg.sv
// Shared types and constants for the archer run-control block and its
// per-hart tohost decoders.
package archer_pkg;

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        DONE
    } state_t;

    localparam logic [31:0] TOHOST_DEFAULT = 32'h0000_1000;
    localparam logic [31:0] PASS_CODE      = 32'd1;

endpackage

// File: rtl/archer_tohost_decode.sv
// Per-hart decoder: flags a store to the tohost word and classifies its
// payload as a pass (exactly PASS_CODE) or a failure code.
module archer_tohost_decode
    import archer_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR = TOHOST_DEFAULT
) (
    input  logic        valid,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic        hit,
    output logic        is_pass,
    output logic [30:0] code
);

    assign hit     = valid && (addr == TOHOST_ADDR);
    assign is_pass = (data == PASS_CODE);
    assign code    = data[31:1];

endmodule

// File: rtl/archer_run_ctrl.sv
// Run-control and completion monitor: sequences hart resets, counts run
// cycles and reports pass, first failure or timeout from tohost stores.
module archer_run_ctrl
    import archer_pkg::*;
#(
    parameter int          NUM_HARTS      = 1,
    parameter int          RST_CYCLES     = 2,
    parameter int          TIMEOUT_CYCLES = 100,
    parameter int          CNT_W          = 32,
    parameter logic [31:0] TOHOST_ADDR    = TOHOST_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [NUM_HARTS-1:0]    core_rst_n,
    input  logic [NUM_HARTS-1:0]    st_valid,
    input  logic [NUM_HARTS*32-1:0] st_addr,
    input  logic [NUM_HARTS*32-1:0] st_data,
    output logic                    run,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [2:0]              fail_hart,
    output logic [30:0]             fail_code,
    output logic [CNT_W-1:0]        cycle_count
);

    localparam logic [31:0] HOLD_LAST = 32'(RST_CYCLES - 1);
    localparam logic [63:0] TO_LAST   = 64'(TIMEOUT_CYCLES) - 64'd1;

    state_t                 state, state_next;
    logic [31:0]            hold_cnt, hold_next;
    logic [NUM_HARTS-1:0]   finished, fin_next;
    logic                   fail_seen, seen_next;
    logic [CNT_W-1:0]       cnt_next, cnt_sat;
    logic [2:0]             fh_next, low_idx;
    logic [30:0]            fc_next, low_code;
    logic                   pass_next, to_next;

    logic [NUM_HARTS-1:0]   hit, is_pass, new_hit, new_fail;
    logic [30:0]            code [NUM_HARTS];

    for (genvar i = 0; i < NUM_HARTS; i++) begin : g_dec
        archer_tohost_decode #(
            .TOHOST_ADDR(TOHOST_ADDR)
        ) u_dec (
            .valid  (st_valid[i]),
            .addr   (st_addr[32*i +: 32]),
            .data   (st_data[32*i +: 32]),
            .hit    (hit[i]),
            .is_pass(is_pass[i]),
            .code   (code[i])
        );
    end

    assign new_hit  = hit & ~finished;
    assign new_fail = new_hit & ~is_pass;
    assign cnt_sat  = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);

    // Descending scan so the lowest-index same-cycle failure is the one kept.
    always_comb begin
        low_idx  = '0;
        low_code = '0;
        for (int i = NUM_HARTS - 1; i >= 0; i--) begin
            if (new_fail[i]) begin
                low_idx  = 3'(i);
                low_code = code[i];
            end
        end
    end

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        fin_next   = finished;
        seen_next  = fail_seen;
        cnt_next   = cycle_count;
        fh_next    = fail_hart;
        fc_next    = fail_code;
        pass_next  = pass;
        to_next    = timeout;
        case (state)
            HOLD: begin
                hold_next = hold_cnt + 32'd1;
                if (hold_cnt == HOLD_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                fin_next = finished | new_hit;
                if ((new_fail != '0) && !fail_seen) begin
                    seen_next = 1'b1;
                    fh_next   = low_idx;
                    fc_next   = low_code;
                end
                // Completion beats timeout and freezes the count where it is.
                if (&fin_next) begin
                    state_next = DONE;
                    pass_next  = (new_fail == '0) && !fail_seen;
                end else begin
                    cnt_next = cnt_sat;
                    if (64'(cnt_sat) >= TO_LAST) begin
                        state_next = DONE;
                        to_next    = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HOLD;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt    <= '0;
            finished    <= '0;
            fail_seen   <= 1'b0;
            cycle_count <= '0;
            fail_hart   <= '0;
            fail_code   <= '0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            run         <= 1'b0;
            done        <= 1'b0;
            core_rst_n  <= '0;
        end else begin
            hold_cnt    <= hold_next;
            finished    <= fin_next;
            fail_seen   <= seen_next;
            cycle_count <= cnt_next;
            fail_hart   <= fh_next;
            fail_code   <= fc_next;
            pass        <= pass_next;
            timeout     <= to_next;
            run         <= (state_next == RUN);
            done        <= (state_next == DONE);
            core_rst_n  <= {NUM_HARTS{state_next == RUN}};
        end
    end

endmodule

// File: tb/tb_archer_run_ctrl.sv
// Self-checking bench for archer_run_ctrl: directed and random store plans
// are compared against an outcome model computed from the plan as a whole.
module tb_archer_run_ctrl;
    import archer_pkg::*;

    localparam int          NH   = 2;
    localparam int          RSTC = 2;
    localparam int          TO   = 100;
    localparam int          CW   = 32;
    localparam logic [31:0] TH   = 32'h0000_1000;

    logic            clk = 1'b0;
    logic            rst;
    logic [NH-1:0]   core_rst_n;
    logic [NH-1:0]   st_valid;
    logic [NH*32-1:0] st_addr;
    logic [NH*32-1:0] st_data;
    logic            run, done, pass, timeout;
    logic [2:0]      fail_hart;
    logic [30:0]     fail_code;
    logic [CW-1:0]   cycle_count;

    int checks = 0;
    int errors = 0;

    // Store plan: first tohost store per hart (-1 = never) and an optional repeat.
    int          p_cyc   [NH];
    logic [31:0] p_data  [NH];
    int          rep_cyc [NH];
    logic [31:0] rep_data[NH];

    int          exp_end, exp_cnt, exp_fh;
    bit          exp_to, exp_pass;
    logic [30:0] exp_fc;

    archer_run_ctrl #(
        .NUM_HARTS     (NH),
        .RST_CYCLES    (RSTC),
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (CW),
        .TOHOST_ADDR   (TH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_rst_n (core_rst_n),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .run        (run),
        .done       (done),
        .pass       (pass),
        .timeout    (timeout),
        .fail_hart  (fail_hart),
        .fail_code  (fail_code),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog got no_finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outcome from the plan: completion time is the latest first store,
    // otherwise the run ends at the last counted cycle before timeout.
    task automatic computeExpected();
        int comp;
        int best;
        bit all_fin;
        comp    = -1;
        all_fin = 1'b1;
        for (int h = 0; h < NH; h++) begin
            if (p_cyc[h] < 0) all_fin = 1'b0;
            else if (p_cyc[h] > comp) comp = p_cyc[h];
        end
        if (all_fin && comp <= TO - 2) begin
            exp_end = comp;
            exp_cnt = comp;
            exp_to  = 1'b0;
        end else begin
            exp_end = TO - 2;
            exp_cnt = TO - 1;
            exp_to  = 1'b1;
        end
        best = -1;
        for (int h = 0; h < NH; h++) begin
            if (p_cyc[h] >= 0 && p_cyc[h] <= exp_end && p_data[h] != PASS_CODE) begin
                if (best < 0 || p_cyc[h] < p_cyc[best]) best = h;
            end
        end
        exp_pass = !exp_to && (best < 0);
        exp_fh   = (best < 0) ? 0 : best;
        exp_fc   = (best < 0) ? 31'd0 : p_data[best][31:1];
    endtask

    task automatic driveIdle();
        st_valid = '0;
        st_addr  = '0;
        st_data  = '0;
    endtask

    task automatic driveTohostAll();
        for (int h = 0; h < NH; h++) begin
            st_valid[h]         = 1'b1;
            st_addr[32*h +: 32] = TH;
            st_data[32*h +: 32] = ($urandom_range(0, 1) == 1) ? PASS_CODE : 32'($urandom);
        end
    endtask

    task automatic applyStimulus(input int c);
        for (int h = 0; h < NH; h++) begin
            if (c == p_cyc[h]) begin
                st_valid[h]         = 1'b1;
                st_addr[32*h +: 32] = TH;
                st_data[32*h +: 32] = p_data[h];
            end else if (c == rep_cyc[h]) begin
                st_valid[h]         = 1'b1;
                st_addr[32*h +: 32] = TH;
                st_data[32*h +: 32] = rep_data[h];
            end else begin
                st_valid[h]         = 1'($urandom_range(0, 1));
                st_addr[32*h +: 32] = TH + 32'(4 * $urandom_range(1, 15));
                st_data[32*h +: 32] = ($urandom_range(0, 1) == 1) ? PASS_CODE : 32'($urandom);
            end
        end
    endtask

    task automatic setPlan(input int c0, input logic [31:0] d0, input int r0, input logic [31:0] rd0,
                           input int c1, input logic [31:0] d1, input int r1, input logic [31:0] rd1);
        p_cyc[0] = c0; p_data[0] = d0; rep_cyc[0] = r0; rep_data[0] = rd0;
        p_cyc[1] = c1; p_data[1] = d1; rep_cyc[1] = r1; rep_data[1] = rd1;
    endtask

    task automatic randomPlan();
        for (int h = 0; h < NH; h++) begin
            p_cyc[h]    = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 110));
            p_data[h]   = ($urandom_range(0, 1) == 1) ? PASS_CODE : 32'($urandom);
            rep_cyc[h]  = (p_cyc[h] >= 0 && $urandom_range(0, 1) == 1) ? p_cyc[h] + int'($urandom_range(1, 5)) : -1;
            rep_data[h] = 32'($urandom);
        end
    endtask

    task automatic runEpisode(input string name);
        int c;
        bit seen;
        computeExpected();
        @(negedge clk);
        rst = 1'b1;
        driveIdle();
        @(negedge clk);
        rst = 1'b0;
        driveTohostAll();
        @(negedge clk);
        checkOutput({name, ".hold_core_rst_n"}, 64'(core_rst_n), 64'd0);
        driveTohostAll();
        @(negedge clk);
        checkOutput({name, ".rise_core_rst_n"}, 64'(core_rst_n), 64'(2'b11));
        checkOutput({name, ".rise_count"}, 64'(cycle_count), 64'd0);
        seen = 1'b0;
        for (c = 0; c < TO + 20; c++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            applyStimulus(c);
            @(negedge clk);
        end
        checkOutput({name, ".done_seen"}, 64'(seen), 64'd1);
        checkOutput({name, ".done_cycle"}, 64'(c), 64'(exp_end + 1));
        repeat (3) begin
            driveTohostAll();
            @(negedge clk);
        end
        driveIdle();
        checkOutput({name, ".done"}, 64'(done), 64'd1);
        checkOutput({name, ".run"}, 64'(run), 64'd0);
        checkOutput({name, ".core_rst_n"}, 64'(core_rst_n), 64'd0);
        checkOutput({name, ".pass"}, 64'(pass), 64'(exp_pass));
        checkOutput({name, ".timeout"}, 64'(timeout), 64'(exp_to));
        checkOutput({name, ".fail_hart"}, 64'(fail_hart), 64'(exp_fh));
        checkOutput({name, ".fail_code"}, 64'(fail_code), 64'(exp_fc));
        checkOutput({name, ".cycle_count"}, 64'(cycle_count), 64'(exp_cnt));
    endtask

    task automatic testMidReset();
        setPlan(-1, 32'd0, -1, 32'd0, 5, 32'hFFFF_FFFF, -1, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        driveIdle();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 30; c++) begin
            applyStimulus(c);
            @(negedge clk);
        end
        checkOutput("mid.run_before", 64'(run), 64'd1);
        checkOutput("mid.fail_hart_before", 64'(fail_hart), 64'd1);
        checkOutput("mid.count_before", 64'(cycle_count), 64'd30);
        rst = 1'b1;
        driveIdle();
        @(negedge clk);
        checkOutput("mid.core_rst_n", 64'(core_rst_n), 64'd0);
        checkOutput("mid.run", 64'(run), 64'd0);
        checkOutput("mid.done", 64'(done), 64'd0);
        checkOutput("mid.pass", 64'(pass), 64'd0);
        checkOutput("mid.timeout", 64'(timeout), 64'd0);
        checkOutput("mid.fail_hart", 64'(fail_hart), 64'd0);
        checkOutput("mid.fail_code", 64'(fail_code), 64'd0);
        checkOutput("mid.cycle_count", 64'(cycle_count), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid.rehold", 64'(core_rst_n), 64'd0);
        @(negedge clk);
        checkOutput("mid.rerun_core_rst_n", 64'(core_rst_n), 64'(2'b11));
        checkOutput("mid.rerun_run", 64'(run), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        driveIdle();
        repeat (2) @(negedge clk);
        checkOutput("reset.core_rst_n", 64'(core_rst_n), 64'd0);
        checkOutput("reset.done", 64'(done), 64'd0);
        checkOutput("reset.run", 64'(run), 64'd0);

        setPlan(-1, 32'd0, -1, 32'd0, -1, 32'd0, -1, 32'd0);
        runEpisode("no_stores");
        setPlan(40, 32'd1, -1, 32'd0, 10, 32'd1, -1, 32'd0);
        runEpisode("pass40");
        setPlan(20, 32'd1, -1, 32'd0, 10, 32'h0000_0007, -1, 32'd0);
        runEpisode("fail_h1");
        setPlan(15, 32'd5, -1, 32'd0, 15, 32'd9, -1, 32'd0);
        runEpisode("same_cycle_fail");
        setPlan(12, 32'h0000_00AB, 13, 32'd1, 14, 32'd9, 20, 32'd3);
        runEpisode("repeat_store");
        setPlan(50, 32'd1, -1, 32'd0, 98, 32'd1, -1, 32'd0);
        runEpisode("complete_on_timeout");
        setPlan(3, 32'h0000_0010, 4, 32'd1, -1, 32'd0, -1, 32'd0);
        runEpisode("timeout_keeps_fail");
        testMidReset();
        for (int e = 0; e < 20; e++) begin
            randomPlan();
            runEpisode($sformatf("rand%0d", e));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
